redirect_ctrl: RTL
==================

# redirect_ctrl

Fetch-side PC sequencer and pipeline control for the three-stage core. It consumes `jump_en_i`, `jump_addr_i` and `hold_flag_i` from the execute stage, owns the architectural fetch PC, and drives flush and hold to the IF/ID and ID/EX pipeline registers. It also detects misaligned redirect targets and vectors them to a trap address. A saturating redirect counter and a hold-timeout watchdog support debug.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `TRAP_VEC`, 32'h0000_0100: PC loaded on a misaligned redirect target.
- `HOLD_MAX`, 16: number of consecutive hold cycles after which the watchdog fires (range 1..255).

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `jump_en_i`  in  1: execute stage requests a redirect this cycle.
- `jump_addr_i`  in  32: redirect target, valid when `jump_en_i`=1.
- `hold_flag_i`  in  1: execute stage requests a pipeline freeze this cycle.
- `pc_o`  out  32: current fetch address (registered).
- `inst_valid_o`  out  1: `pc_o` is a valid fetch address (registered).
- `flush_o`  out  1: combinational; IF/ID and ID/EX load NOP on the next edge.
- `hold_o`  out  1: combinational; IF/ID and ID/EX keep their contents on the next edge.
- `trap_o`  out  1: registered one-cycle pulse marking a misaligned redirect.
- `trap_addr_o`  out  32: last offending target (registered, sticky until the next trap).
- `redirect_cnt_o`  out  16: count of accepted redirects, saturating at 16'hFFFF.
- `hold_timeout_o`  out  1: sticky watchdog flag, cleared only by reset.

## Operation
- States:
  - BOOT: entered on reset; lasts exactly one cycle.
  - RUN: normal operation.
  - HOLD: pipeline frozen.
- Target alignment: `tgt = jump_addr_i & ~32'h1` (bit 0 cleared, as for JALR). The target is misaligned when `tgt[1]`=1.
- Redirect accept: `acc = jump_en_i` while in RUN or HOLD. In BOOT, all inputs are ignored.
- Priority per cycle: reset > redirect > hold > sequential increment.
- BOOT:
  - `inst_valid_o`=0; `pc_o` holds `RESET_PC`.
  - Next state is RUN unconditionally; `pc_o` is not incremented on exit.
- RUN or HOLD with `acc`=1:
  - `flush_o`=1 and `hold_o`=0 in the same cycle.
  - Next `pc_o` = `tgt`, or `TRAP_VEC` if `tgt` is misaligned.
  - On a misaligned target: next `trap_o`=1 and next `trap_addr_o`=`tgt`.
  - `redirect_cnt_o` increments unless already saturated.
  - Next state is RUN, and the hold counter clears.
- RUN or HOLD with `acc`=0 and `hold_flag_i`=1:
  - `hold_o`=1; `pc_o` is unchanged.
  - Next state is HOLD; the hold counter increments, saturating at 255.
- RUN or HOLD with `acc`=0 and `hold_flag_i`=0:
  - Next `pc_o` = `pc_o` + 32'd4, wrapping modulo 2^32 (FFFF_FFFC -> 0000_0000).
  - Next state is RUN; the hold counter clears.
- Watchdog: when the hold counter reaches `HOLD_MAX` while `hold_flag_i`=1, `hold_timeout_o` sets on the next edge. No other action is taken.
- `inst_valid_o` is 1 in RUN and HOLD, and 0 only in BOOT.
- `trap_o` is 0 in every cycle except the one following a misaligned accept.
- Back-to-back redirects on consecutive cycles are each accepted independently.

## Timing
- Reset values (all applied while `rst_n`=0 at a rising edge):
  - `pc_o`=`RESET_PC`
  - `inst_valid_o`=0
  - `trap_o`=0
  - `trap_addr_o`=0
  - `redirect_cnt_o`=0
  - `hold_timeout_o`=0
  - state=BOOT, hold counter=0
- While `rst_n`=0: `flush_o`=0 and `hold_o`=0, regardless of other inputs.
- Reset asserted mid-hold or mid-redirect: reset wins on that edge; no partial update.
- Redirect latency: `jump_en_i` in cycle N -> `pc_o`=target in cycle N+1. `flush_o` is high in cycle N only.
- Hold: `hold_flag_i` in cycle N -> `hold_o` in cycle N, and `pc_o` in N+1 equals `pc_o` in N.
- `flush_o` and `hold_o` are never 1 in the same cycle.
- Combinational paths: inputs -> `flush_o`/`hold_o` only. No combinational path to `pc_o`.

## Test plan
- Reset release with `RESET_PC`=0 and no events:
  - `inst_valid_o`=0 for one cycle.
  - `pc_o` then reads 0, 4, 8, 12 on successive cycles.
- `jump_en_i`=1 with `jump_addr_i`=32'h0000_0081 in cycle N:
  - `flush_o`=1 in N.
  - `pc_o`=32'h0000_0080 in N+1.
  - `redirect_cnt_o`=1; `trap_o` stays 0.
- `jump_addr_i`=32'h0000_0042 (bit 1 set):
  - `pc_o`=`TRAP_VEC` (32'h100) in N+1.
  - `trap_o`=1 for exactly one cycle; `trap_addr_o`=32'h42.
- `hold_flag_i`=1 for 3 cycles starting at `pc_o`=32'h10:
  - `hold_o`=1 for those 3 cycles; `pc_o` stays at 32'h10.
  - After release, `pc_o` reads 32'h14.
  - With `jump_en_i` and `hold_flag_i` both high in one cycle: redirect taken, `hold_o`=0.
- Wrap and saturation:
  - `pc_o`=32'hFFFF_FFFC with no event -> `pc_o`=0 next cycle.
  - 65537 redirects -> `redirect_cnt_o` saturates at 16'hFFFF.
- Watchdog with `HOLD_MAX`=16: `hold_flag_i` held for 20 cycles -> `hold_timeout_o` sets and stays set. Then `rst_n`=0 asserted mid-hold -> all outputs return to their reset values on that edge.

Source files
------------

// File: rtl/redirect_ctrl.sv
// Fetch-side PC sequencer for the three-stage core. Owns the fetch PC and
// drives flush/hold to the IF/ID and ID/EX registers. Misaligned redirect
// targets are sent to a trap vector. A saturating redirect counter and a
// hold-timeout watchdog are included for debug visibility.
module redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  output logic        flush_o,
  output logic        hold_o,
  output logic        trap_o,
  output logic [31:0] trap_addr_o,
  output logic [15:0] redirect_cnt_o,
  output logic        hold_timeout_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_inst_valid;
  logic        r_trap;
  logic [31:0] r_trap_addr;
  logic [15:0] r_redirect_cnt;
  logic [7:0]  r_hold_cnt;
  logic        r_hold_timeout;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_trap_nxt;
  logic [31:0] w_trap_addr_nxt;
  logic [15:0] w_redirect_cnt_nxt;
  logic [7:0]  w_hold_cnt_nxt;
  logic        w_hold_timeout_nxt;
  logic [31:0] w_tgt;
  logic        w_active;
  logic        w_acc;
  logic        w_hold;

  // Next-state, next-PC and pipeline-control decode.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case/if tree leaves a value unassigned and infers a latch.
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_trap_nxt         = 1'b0;
    w_trap_addr_nxt    = r_trap_addr;
    w_redirect_cnt_nxt = r_redirect_cnt;
    w_hold_cnt_nxt     = r_hold_cnt;
    w_hold_timeout_nxt = r_hold_timeout;

    // Bit 0 cleared as for JALR; bit 1 then decides alignment.
    w_tgt    = {jump_addr_i[31:1], 1'b0};
    // Reset and the BOOT cycle both mask every input.
    w_active = rst_n && (r_state != ST_BOOT);
    w_acc    = w_active && jump_en_i;
    w_hold   = w_active && !jump_en_i && hold_flag_i;

    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        if (hold_flag_i && (r_hold_cnt >= HOLD_MAX_C)) begin
          w_hold_timeout_nxt = 1'b1;
        end
        if (jump_en_i) begin
          w_state_nxt    = ST_RUN;
          w_hold_cnt_nxt = 8'd0;
          if (r_redirect_cnt != 16'hFFFF) begin
            w_redirect_cnt_nxt = r_redirect_cnt + 16'd1;
          end
          if (w_tgt[1]) begin
            w_pc_nxt        = TRAP_VEC;
            w_trap_nxt      = 1'b1;
            w_trap_addr_nxt = w_tgt;
          end else begin
            w_pc_nxt = w_tgt;
          end
        end else if (hold_flag_i) begin
          w_state_nxt = ST_HOLD;
          if (r_hold_cnt != 8'hFF) begin
            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
          end
        end else begin
          w_state_nxt    = ST_RUN;
          w_hold_cnt_nxt = 8'd0;
          w_pc_nxt       = r_pc + 32'd4;
        end
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled only at the clock edge, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      r_state        <= ST_BOOT;
      r_pc           <= RESET_PC;
      r_inst_valid   <= 1'b0;
      r_trap         <= 1'b0;
      r_trap_addr    <= 32'd0;
      r_redirect_cnt <= 16'd0;
      r_hold_cnt     <= 8'd0;
      r_hold_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      // Every state reachable from here is RUN or HOLD.
      r_inst_valid   <= 1'b1;
      r_trap         <= w_trap_nxt;
      r_trap_addr    <= w_trap_addr_nxt;
      r_redirect_cnt <= w_redirect_cnt_nxt;
      r_hold_cnt     <= w_hold_cnt_nxt;
      r_hold_timeout <= w_hold_timeout_nxt;
    end
  end

  assign pc_o           = r_pc;
  assign inst_valid_o   = r_inst_valid;
  assign flush_o        = w_acc;
  assign hold_o         = w_hold;
  assign trap_o         = r_trap;
  assign trap_addr_o    = r_trap_addr;
  assign redirect_cnt_o = r_redirect_cnt;
  assign hold_timeout_o = r_hold_timeout;

endmodule
